voq_scheduler: RTL and testbench

VOQ_SCHEDULER -- requirements
Module: voq_scheduler

---
 rtl/voq_scheduler.sv | 159 +++++++++++++++
 tb/tb_voq_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voq_scheduler.sv
//------------------------------------------------------------------------------
// Module      : voq_scheduler
// Description : 4x4 crossbar scheduler over virtual output queues. Serves one
//               ingress per cycle, picks an egress by round-robin or a priority
//               list, and guarantees a conflict-free matching.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module voq_scheduler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] voq_empty_all,
  input  logic        policy,
  input  logic [31:0] prio_all,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sched_egress,
  output logic [3:0]  sched_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] empty_snap;
  logic        policy_snap;
  logic [31:0] prio_snap;
  logic [3:0]  picked;
  logic [1:0]  step;
  logic [1:0]  ingress_ptr;
  logic [7:0]  voq_ptr;

  logic [1:0]  cur;
  logic [3:0]  cand_mask;
  logic [7:0]  prio_row;
  logic [1:0]  ptr_cur;
  logic        hit;
  logic [1:0]  hit_egress;
  logic [1:0]  probe;
  logic [7:0]  egress_nxt;
  logic [3:0]  valid_nxt;

  // Ingress served this cycle rotates with ingress_ptr for fairness.
  assign cur       = ingress_ptr + step;
  assign cand_mask = ~empty_snap[{cur, 2'b00} +: 4] & ~picked;
  assign prio_row  = prio_snap[{cur, 3'b000} +: 8];
  assign ptr_cur   = voq_ptr[{cur, 1'b0} +: 2];

  // First-hit search over four probes; order depends on the latched policy.
  always_comb begin
    hit        = 1'b0;
    hit_egress = 2'd0;
    probe      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (policy_snap) begin
        probe = prio_row[(3 - k) * 2 +: 2];
      end else begin
        probe = ptr_cur + 2'(k);
      end
      if (!hit && cand_mask[probe]) begin
        hit        = 1'b1;
        hit_egress = probe;
      end
    end
  end

  // Schedule as it will look after committing the current ingress.
  always_comb begin
    egress_nxt                      = sched_egress;
    valid_nxt                       = sched_valid;
    egress_nxt[{cur, 1'b0} +: 2]    = hit ? hit_egress : 2'd0;
    valid_nxt[cur]                  = hit;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = PICK;
      end
      PICK: begin
        busy = 1'b1;
        if (step == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot capture, per-step commit, and pointer update on the final step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      empty_snap   <= 16'd0;
      policy_snap  <= 1'b0;
      prio_snap    <= 32'd0;
      picked       <= 4'd0;
      step         <= 2'd0;
      ingress_ptr  <= 2'd0;
      voq_ptr      <= 8'd0;
      sched_egress <= 8'd0;
      sched_valid  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            empty_snap  <= voq_empty_all;
            policy_snap <= policy;
            prio_snap   <= prio_all;
            picked      <= 4'd0;
            sched_valid <= 4'd0;
            step        <= 2'd0;
          end
        end
        PICK: begin
          sched_egress <= egress_nxt;
          sched_valid  <= valid_nxt;
          if (hit) picked[hit_egress] <= 1'b1;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            ingress_ptr <= ingress_ptr + 2'd1;
            for (int i = 0; i < 4; i++) begin
              if (valid_nxt[i]) begin
                voq_ptr[i * 2 +: 2] <= egress_nxt[i * 2 +: 2] + 2'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_voq_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_voq_scheduler
// Description : Self-checking bench for voq_scheduler with a reference model
//               and an expected-result queue popped on each done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_voq_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] voq_empty_all = 16'd0;
  logic        policy = 1'b0;
  logic [31:0] prio_all = 32'd0;
  logic        busy;
  logic        done;
  logic [7:0]  sched_egress;
  logic [3:0]  sched_valid;

  voq_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .voq_empty_all (voq_empty_all),
    .policy        (policy),
    .prio_all      (prio_all),
    .busy          (busy),
    .done          (done),
    .sched_egress  (sched_egress),
    .sched_valid   (sched_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [7:0] eg;
    logic [3:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int m_iptr;
  int m_vptr[4];

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic conflict(input logic [7:0] eg, input logic [3:0] v);
    conflict = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (v[i] && v[j] && (eg[i*2 +: 2] == eg[j*2 +: 2])) conflict = 1'b1;
  endfunction

  // Reference model: computes one schedule and advances the model pointers.
  task automatic model(input logic [15:0] e, input logic p, input logic [31:0] pr,
                       output logic [7:0] eg, output logic [3:0] v);
    logic [3:0] pk;
    int cur;
    int c;
    pk = 4'd0;
    eg = 8'd0;
    v  = 4'd0;
    for (int s = 0; s < 4; s++) begin
      cur = (m_iptr + s) % 4;
      for (int k = 0; k < 4; k++) begin
        if (p) c = int'(pr[cur*8 + 6 - 2*k +: 2]);
        else   c = (m_vptr[cur] + k) % 4;
        if (!e[cur*4 + c] && !pk[c]) begin
          pk[c]            = 1'b1;
          v[cur]           = 1'b1;
          eg[cur*2 +: 2]   = c[1:0];
          break;
        end
      end
    end
    for (int i = 0; i < 4; i++)
      if (v[i]) m_vptr[i] = (int'(eg[i*2 +: 2]) + 1) % 4;
    m_iptr = (m_iptr + 1) % 4;
  endtask

  // Compare each done pulse against the oldest expected schedule.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_val("sched_egress", {24'd0, sched_egress}, {24'd0, mon_e.eg});
        check_val("sched_valid",  {28'd0, sched_valid},  {28'd0, mon_e.v});
        check_val("matching", {31'd0, conflict(sched_egress, sched_valid)}, 32'd0);
      end
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    m_iptr  = 0;
    for (int i = 0; i < 4; i++) m_vptr[i] = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Launch one schedule; inputs are scrambled after the start edge.
  task automatic run_sched(input logic [15:0] e, input logic p, input logic [31:0] pr,
                           input bit ovr, input logic [7:0] oeg, input logic [3:0] ov);
    exp_t x;
    int   n;
    bit   got;
    voq_empty_all = e;
    policy        = p;
    prio_all      = pr;
    start         = 1'b1;
    model(e, p, pr, x.eg, x.v);
    if (ovr) begin
      x.eg = oeg;
      x.v  = ov;
    end
    sb.push_back(x);
    @(posedge clk);
    #1 start = 1'b0;
    voq_empty_all = 16'($urandom);
    policy        = 1'($urandom);
    prio_all      = $urandom;
    n   = 0;
    got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) check_val("busy_in_pick", {31'd0, busy}, 32'd1);
      if (done) got = 1'b1;
    end
    check_val("done_latency", n, 5);
    @(posedge clk);
    #1;
  endtask

  int d0;
  logic [7:0] r_prio;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();
    @(negedge clk);
    check_val("reset_busy",   {31'd0, busy}, 32'd0);
    check_val("reset_done",   {31'd0, done}, 32'd0);
    check_val("reset_egress", {24'd0, sched_egress}, 32'd0);
    check_val("reset_valid",  {28'd0, sched_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Round-robin from fresh pointers, then the rotated second pass.
    run_sched(16'h0000, 1'b0, 32'd0, 1'b1, 8'hE4, 4'hF);
    run_sched(16'h0000, 1'b0, 32'd0, 1'b1, 8'h39, 4'hF);

    // All-empty: no grants, ingress_ptr advances, voq_ptr untouched.
    apply_reset();
    run_sched(16'hFFFF, 1'b0, 32'd0, 1'b1, 8'h00, 4'h0);
    run_sched(16'h0000, 1'b0, 32'd0, 1'b1, 8'h93, 4'hF);

    // Priority list with a single non-empty egress per ingress.
    apply_reset();
    run_sched(16'hBBBB, 1'b1, 32'h1B1B1B1B, 1'b1, 8'h02, 4'h1);

    // A start during PICK must not queue a second schedule.
    d0 = done_cnt;
    voq_empty_all = 16'h0000;
    policy        = 1'b0;
    start         = 1'b1;
    begin
      exp_t x;
      model(16'h0000, 1'b0, 32'd0, x.eg, x.v);
      sb.push_back(x);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check_val("single_done", done_cnt - d0, 1);

    // Reset at step 2 aborts without a done pulse or pointer update.
    d0 = done_cnt;
    voq_empty_all = 16'h0000;
    start         = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_val("abort_busy",   {31'd0, busy}, 32'd0);
    check_val("abort_done",   {31'd0, done}, 32'd0);
    check_val("abort_egress", {24'd0, sched_egress}, 32'd0);
    check_val("abort_valid",  {28'd0, sched_valid}, 32'd0);
    apply_reset();
    repeat (8) @(posedge clk);
    #1;
    check_val("abort_no_done", done_cnt - d0, 0);
    run_sched(16'h0000, 1'b0, 32'd0, 1'b1, 8'hE4, 4'hF);

    // Randomised mix of both policies against the model.
    for (int t = 0; t < 24; t++) begin
      r_prio = 8'($urandom);
      run_sched(16'($urandom) | 16'($urandom), 1'($urandom),
                (t % 3 == 0) ? {4{r_prio}} : $urandom, 1'b0, 8'd0, 4'd0);
    end

    if (sb.size() != 0) check_val("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
